// File: rtl/enc16_pkg.sv
// enc16_pkg: shared types, widths and popcount helper for the round-robin request encoder
package enc16_pkg;
  localparam int N_LINES = 16;
  localparam int CODE_W = 4;
  typedef enum logic {IDLE, PRESENT} enc_state_t;
  function automatic logic [CODE_W:0] popcount16(input logic [N_LINES-1:0] v);
    logic [CODE_W:0] s;
    s = '0;
    for (int i = 0; i < N_LINES; i++) s = s + {{CODE_W{1'b0}}, v[i]};
    return s;
  endfunction
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: combinational round-robin pick of the first set mask bit at or above ptr, wrapping
module rr_pick16
  import enc16_pkg::*;
(
  input  logic [N_LINES-1:0] mask_i,
  input  logic [CODE_W-1:0]  ptr_i,
  output logic [CODE_W-1:0]  idx_o,
  output logic               any_o
);
  logic [N_LINES-1:0] rot;
  logic [CODE_W-1:0]  off;
  assign rot = N_LINES'({mask_i, mask_i} >> ptr_i);
  always_comb begin
    off = '0;
    for (int j = N_LINES - 1; j >= 0; j--) if (rot[j]) off = CODE_W'(j);
  end
  assign idx_o = ptr_i + off;
  assign any_o = |mask_i;
endmodule

// File: rtl/enc16_rr.sv
// enc16_rr: 16-line rising-edge request encoder emitting one 4-bit code per Valid/Ack handshake,
// arbitrated round-robin from the slot after the last granted code.
module enc16_rr
  import enc16_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_LINES-1:0] req_i,
  input  logic               ack_i,
  output logic [CODE_W-1:0]  code_o,
  output logic               valid_o,
  output logic [CODE_W:0]    pend_count_o,
  output logic               overrun_o
);
  enc_state_t         state_q;
  logic [N_LINES-1:0] req_q, pend_q, pend_d, rise, clr;
  logic [CODE_W-1:0]  ptr_q, code_q, pick_idx;
  logic [CODE_W:0]    pend_count_q;
  logic               valid_q, ovr_q, ovr_d, pick_any;
  assign rise = req_i & ~req_q;
  assign clr = (valid_q && ack_i) ? ({{(N_LINES-1){1'b0}}, 1'b1} << code_q) : '0;
  // a rise landing on the bit being cleared re-posts it without counting as an overrun
  assign pend_d = (pend_q & ~clr) | rise;
  assign ovr_d = |(rise & pend_q & ~clr);
  rr_pick16 u_pick (
    .mask_i(pend_q),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_q        <= '0;
      pend_q       <= '0;
      ptr_q        <= '0;
      code_q       <= '0;
      valid_q      <= 1'b0;
      pend_count_q <= '0;
      ovr_q        <= 1'b0;
    end else begin
      req_q        <= req_i;
      pend_q       <= pend_d;
      pend_count_q <= popcount16(pend_d);
      ovr_q        <= ovr_d;
      if (state_q == IDLE) begin
        if (pick_any) begin
          code_q  <= pick_idx;
          valid_q <= 1'b1;
          state_q <= PRESENT;
        end
      end else if (ack_i) begin
        valid_q <= 1'b0;
        ptr_q   <= code_q + 1'b1;
        state_q <= IDLE;
      end
    end
  end
  assign code_o       = code_q;
  assign valid_o      = valid_q;
  assign pend_count_o = pend_count_q;
  assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_enc16_rr.sv
// tb_enc16_rr: directed scoreboard bench; stimulus pushes expected codes, a monitor pops them on each transfer
module tb_enc16_rr;
  logic        clk_i = 1'b0;
  logic        rst_i, ack_i;
  logic [15:0] req_i;
  logic [3:0]  code_o;
  logic        valid_o, overrun_o;
  logic [4:0]  pend_count_o;
  int          total = 0, bad = 0, ovr_cnt = 0;
  int          sb[$];

  enc16_rr dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .ack_i       (ack_i),
    .code_o      (code_o),
    .valid_o     (valid_o),
    .pend_count_o(pend_count_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid_o && n < 20) begin
      tick();
      n++;
    end
    if (!valid_o) chk({name, "_timeout"}, 0, 1);
  endtask

  // monitor: every transfer edge (valid & ack) must match the oldest expected code
  always @(negedge clk_i) begin
    if (!rst_i && overrun_o) ovr_cnt++;
    if (!rst_i && valid_o && ack_i) begin
      if (sb.size() == 0) chk("unexpected_transfer", int'(code_o), -1);
      else chk("sb_code", int'(code_o), sb.pop_front());
    end
  end

  initial begin
    rst_i = 1'b1;
    ack_i = 1'b0;
    req_i = '0;
    tick();
    tick();
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_code", int'(code_o), 0);
    chk("rst_pend", int'(pend_count_o), 0);
    chk("rst_ptr", int'(dut.ptr_q), 0);
    chk("rst_ovr", int'(overrun_o), 0);
    rst_i = 1'b0;
    // single request, ack held high
    ack_i = 1'b1;
    sb.push_back(5);
    req_i[5] = 1'b1;
    tick();
    chk("s_pend1", int'(pend_count_o), 1);
    chk("s_valid_early", int'(valid_o), 0);
    tick();
    chk("s_valid", int'(valid_o), 1);
    chk("s_code", int'(code_o), 5);
    tick();
    chk("s_valid_drop", int'(valid_o), 0);
    chk("s_pend0", int'(pend_count_o), 0);
    chk("s_ptr", int'(dut.ptr_q), 6);
    req_i = '0;
    // round robin from ptr 6: 9, 14, 3
    sb.push_back(9);
    sb.push_back(14);
    sb.push_back(3);
    req_i[3] = 1'b1;
    req_i[9] = 1'b1;
    req_i[14] = 1'b1;
    tick();
    chk("rr_pend", int'(pend_count_o), 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_valid", int'(valid_o), 1);
      chk("rr_pend_at_valid", int'(pend_count_o), 3 - k);
      tick();
    end
    chk("rr_pend_end", int'(pend_count_o), 0);
    chk("rr_ptr", int'(dut.ptr_q), 4);
    req_i = '0;
    // stall with ack low
    ack_i = 1'b0;
    sb.push_back(0);
    sb.push_back(1);
    req_i[0] = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) req_i[1] = 1'b1;
      tick();
      chk("st_valid", int'(valid_o), 1);
      chk("st_code", int'(code_o), 0);
    end
    chk("st_pend", int'(pend_count_o), 2);
    ack_i = 1'b1;
    tick();
    chk("st_drop", int'(valid_o), 0);
    tick();
    chk("st_code1", int'(code_o), 1);
    tick();
    chk("st_ptr", int'(dut.ptr_q), 2);
    req_i = '0;
    // move ptr to 15 by granting 14
    sb.push_back(14);
    req_i[14] = 1'b1;
    tick();
    wait_valid("wrap_setup");
    tick();
    chk("w_ptr15", int'(dut.ptr_q), 15);
    req_i = '0;
    ack_i = 1'b0;
    sb.push_back(15);
    sb.push_back(0);
    sb.push_back(15);
    req_i[15] = 1'b1;
    req_i[0] = 1'b1;
    tick();
    chk("w_pend2", int'(pend_count_o), 2);
    tick();
    chk("w_code15", int'(code_o), 15);
    req_i[15] = 1'b0;
    tick();
    // ack bit 15 in the same cycle it rises again
    ack_i = 1'b1;
    req_i[15] = 1'b1;
    tick();
    chk("w_sim_valid", int'(valid_o), 0);
    chk("w_sim_pend", int'(pend_count_o), 2);
    chk("w_sim_ovr", int'(overrun_o), 0);
    chk("w_ptr0", int'(dut.ptr_q), 0);
    tick();
    chk("w_code0", int'(code_o), 0);
    tick();
    tick();
    chk("w_code15b", int'(code_o), 15);
    tick();
    chk("w_ptr_wrap", int'(dut.ptr_q), 0);
    chk("w_pend_end", int'(pend_count_o), 0);
    // overrun: 7 rises, falls, rises again before ack
    ack_i = 1'b0;
    req_i = '0;
    tick();
    sb.push_back(7);
    req_i[7] = 1'b1;
    tick();
    req_i[7] = 1'b0;
    tick();
    chk("o_no_ovr", int'(overrun_o), 0);
    req_i[7] = 1'b1;
    tick();
    chk("o_ovr", int'(overrun_o), 1);
    chk("o_pend", int'(pend_count_o), 1);
    tick();
    chk("o_ovr_pulse", int'(overrun_o), 0);
    ack_i = 1'b1;
    tick();
    chk("o_pend0", int'(pend_count_o), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("o_no_repeat", int'(valid_o), 0);
    end
    // reset mid-handshake with 4 pending
    ack_i = 1'b0;
    req_i = '0;
    tick();
    req_i = 16'h0154;
    tick();
    chk("r_pend4", int'(pend_count_o), 4);
    tick();
    chk("r_valid", int'(valid_o), 1);
    chk("r_code8", int'(code_o), 8);
    rst_i = 1'b1;
    req_i = '0;
    tick();
    chk("r_valid0", int'(valid_o), 0);
    chk("r_code0", int'(code_o), 0);
    chk("r_pend0", int'(pend_count_o), 0);
    chk("r_ptr0", int'(dut.ptr_q), 0);
    rst_i = 1'b0;
    ack_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("r_idle", int'(valid_o), 0);
    end
    chk("sb_empty", sb.size(), 0);
    chk("ovr_count", ovr_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enc16_rr.md
# enc16_rr

Round-robin 16-line request encoder: the inverse of the 4-to-16 one-hot decoder. It captures rising edges on 16 request lines into a pending mask and emits one 4-bit code at a time under a Valid/Ack handshake. Arbitration is round-robin. It sits between the switch/button request lines and any consumer that needs a binary index, for example a display driver or an address mux that feeds the decoder.

## Interface
- Parameters: none. Width is fixed at 16 lines in, 4-bit code out.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; clears all state.
- Req  in  16  request lines; a 0→1 transition on bit i posts request i.
- Ack  in  1  consumer accepts the current Code when Valid=1.
- Code  out  4  index of the granted request; stable while Valid=1.
- Valid  out  1  Code is valid.
- PendCount  out  5  number of pending requests, 0..16, registered.
- Overrun  out  1  one-cycle pulse when a rising edge hits an already-pending bit.

## Operation
- Reset value of every register is 0:
  - Req_q, Pending[15:0], Ptr[3:0], Code, Valid, PendCount, Overrun.
  - State = IDLE.
- Edge detection: Rise = Req & ~Req_q. Req_q is registered every cycle.
  - A line already high when Reset deasserts counts as a rise on the first cycle after reset.
- Pending update each edge: Pending_next = (Pending & ~Clr) | Rise.
  - Clr is the one-hot of Code when Valid & Ack, otherwise 0.
  - Simultaneous rise and clear on the same bit: the rise wins and the bit stays pending. No Overrun in this case.
- Overrun = |(Rise & Pending & ~Clr), registered.
- State machine:
  - IDLE: if Pending ≠ 0, pick the first set bit at index ≥ Ptr, scanning upward and wrapping 15→0. Load Code with that index, set Valid=1, go to PRESENT. If Pending = 0, stay in IDLE with Valid=0.
  - PRESENT: hold Code and Valid=1 while Ack=0. When Ack=1: clear that Pending bit, set Ptr = Code+1 (mod 16, so 15 wraps to 0), set Valid=0, return to IDLE.
- Ack while Valid=0 is ignored.
- PendCount = popcount(Pending_next), registered, so it tracks Pending with no extra lag.
- Reset mid-handshake: Valid drops on the next edge and all pending requests are lost.

## Timing
- Latency: Req rises before edge k, so Pending[i] is set at edge k. Valid=1 and Code=i follow at edge k+1, provided the block is IDLE and i wins the pick.
- Handshake: transfer happens on any edge with Valid=1 and Ack=1. Valid is 0 for at least one cycle after each transfer.
  - Maximum throughput is one code per 2 cycles.
- Code never changes while Valid=1.
- The pick is combinational from the registered Pending and Ptr. Outputs are registered with no combinational Req→output path.

## Structure
- Package enc16_pkg holds:
  - typedef enum logic {IDLE, PRESENT} enc_state_t;
  - localparam N_LINES=16 and CODE_W=4.
- Sub-module rr_pick16 (combinational):
  - Inputs: Mask[15:0], Ptr[3:0].
  - Outputs: Idx[3:0], Any.
  - Implementation: rotate the mask by Ptr, find the lowest set bit, add Ptr back mod 16.
- Top level holds Req_q, Pending, Ptr, the FSM, PendCount and Overrun.

## Test plan
- Reset then single request: Req[5] 0→1 with Ack held 1. Required: Valid=1 and Code=5 two edges after the rise, Valid=0 the next cycle, PendCount goes 1→0, Ptr=6.
- Round-robin order: with Ptr=6, raise Req[3], Req[9] and Req[14] in the same cycle, Ack=1. Required: codes 9, 14, 3 in that order. PendCount reads 3,2,1,0 at the Valid edges. Ptr ends at 4.
- Stall: Req[0] rises with Ack=0 for 5 cycles. Required: Code=0 and Valid=1 held stable throughout. Raising Req[1] meanwhile does not change Code. Code=1 follows after Ack.
- Wrap and simultaneous events:
  - Ptr=15 with Req[15] and Req[0] pending gives 15 then 0.
  - A new rise on bit 15 in the same cycle it is acked leaves bit 15 pending with no Overrun.
- Overrun: Req[7] rises, falls, then rises again before it is acked. Required: a single Overrun pulse one edge after the second rise, PendCount stays 1, code 7 is issued only once.
- Reset mid-operation: assert Reset for one edge while Valid=1 with 4 requests pending. Required: Valid=0, Code=0, PendCount=0, Ptr=0 after that edge, and no further codes unless Req rises again.
